psram_qspi_controller: RTL and testbench
========================================

// Module: psram_qspi_controller
// PURPOSE
//  Sequences the external SPI/QSPI PSRAM on the tangnano board: power-up delay,
//  reset-enable/reset commands, then single-byte quad read (0xEB) and quad write (0x38).
//  Sits between the framebuffer/host request logic and the PSRAM pins.
//  Owns chip-select, the clock gate, pin direction and the nibble shifting.
//  Serialises one request at a time.
// PARAMETERS
//  POWERUP_CYCLES   15000  sclk cycles to wait after reset before the first command (>=150us)
//  WAIT_CYCLES      6      dummy cycles between address and data for a 0xEB read
//  DESELECT_CYCLES  2      minimum cycles ce_n stays high between transactions (>=1)
// PORTS
//  sclk           in   1   controller clock; PSRAM clock = ~sclk gated by psram_clk_en
//  reset          in   1   async, active-high
//  req_valid      in   1   request present
//  req_ready      out  1   controller idle and initialised; accept when valid&ready at rising sclk
//  req_write      in   1   1=write, 0=read
//  req_addr       in   24  byte address
//  req_wdata      in   8   write byte
//  rsp_valid      out  1   one-cycle pulse: transaction finished
//  rsp_rdata      out  8   read byte, valid with rsp_valid; 0 for writes
//  init_done      out  1   high once reset-enable/reset have been sent; stays high until reset
//  psram_ce_n     out  1   chip select, active low
//  psram_clk_en   out  1   1 = PSRAM clock toggles this cycle
//  sio_out        out  4   data to PSRAM; bit0 = SI in 1-bit mode
//  sio_oe         out  4   per-pin output enable
//  sio_in         in   4   data from PSRAM; bit1 = SO in 1-bit mode
// BEHAVIOUR
//  Reset (async): ce_n=1, clk_en=0, sio_oe=0, sio_out=0, req_ready=0, rsp_valid=0,
//   rsp_rdata=0, init_done=0, state=POWERUP, counters cleared. Reset mid-transaction
//   aborts it immediately. No rsp_valid is produced for the aborted request.
//  All outputs are registered and change on rising sclk. The PSRAM samples at the
//   falling sclk edge. sio_in is captured on the rising edge that ends each data cycle.
//  States: POWERUP -> INIT_CMD(0x66) -> DESEL -> INIT_CMD(0x99) -> DESEL -> IDLE ->
//   CMD -> ADDR -> [WAIT, reads only] -> DATA -> DESEL -> IDLE.
//  POWERUP: counts POWERUP_CYCLES with ce_n=1, then enters the init sequence.
//  INIT_CMD/CMD: ce_n=0, clk_en=1, sio_oe=4'b0001.
//   Sends 8 bits on sio_out[0], MSB first, one per cycle.
//  ADDR: 6 cycles, sio_oe=4'b1111, sio_out=req_addr nibbles [23:20] .. [3:0].
//  WAIT: WAIT_CYCLES cycles, sio_oe=0, clk_en=1, data ignored.
//  DATA: 2 cycles.
//   Write: sio_oe=1111, sio_out=wdata[7:4] then [3:0].
//   Read: sio_oe=0, high nibble captured first.
//  DESEL: ce_n=1, clk_en=0, sio_oe=0 for DESELECT_CYCLES cycles.
//   Leaving the second init DESEL sets init_done=1.
//  req_ready=1 only in IDLE with init_done=1.
//   The accepting edge latches write, addr and wdata; later input changes are ignored.
//  Latency from accepting edge N:
//   Write: 16 clocked cycles; rsp_valid pulses at edge N+17.
//   Read: 22+(WAIT_CYCLES-6) cycles; rsp_valid at N+23 for the default.
//  rsp_valid is asserted in the first DESEL cycle. rsp_rdata holds until the next response.
//  The earliest next acceptance is at the edge after the last DESEL cycle.
//  req_valid before init_done is ignored (not an error, no response).
//  Address bit 23 is passed through unmodified; no page-boundary handling (single byte).
// TESTING
//  1 POWERUP_CYCLES=4, reset pulse -> all reset values.
//    ce_n falls at cycle 5; sio_out[0] = 0,1,1,0,0,1,1,0 (0x66); DESEL x2;
//    then 0x99; init_done=1.
//  2 Write addr 0x123456 data 0x5A -> sio_out[0] serial 0x38;
//    nibbles 1,2,3,4,5,6,5,A with oe=1111; rsp_valid at N+17; ce_n high 2 cycles.
//  3 Read addr 0x000010, model drives 0xC3 -> cmd 0xEB; addr 0,0,0,0,1,0;
//    6 cycles oe=0000; rsp_rdata=0xC3 with rsp_valid at N+23.
//  4 req_valid held high for two reads -> req_ready=0 for the whole transaction;
//    ce_n high >=2 cycles; second CMD starts only after DESEL.
//  5 Reset asserted during WAIT -> ce_n=1, clk_en=0, oe=0 without waiting for a clock edge;
//    no rsp_valid; full POWERUP/init sequence repeats.
//  6 req_valid asserted during POWERUP -> no PSRAM activity and no response;
//    request accepted on the first cycle after init_done.

Source files
------------

// File: rtl/psram_qspi_controller.sv
`default_nettype none
// ============================================================================
//  Module   : psram_qspi_controller
//  Purpose  : Sequences the external SPI/QSPI PSRAM. It waits out the power-up
//             delay, sends reset-enable (0x66) and reset (0x99), then serves
//             one single-byte request at a time as a quad read (0xEB) or a
//             quad write (0x38).
//  Ports    : sclk, reset          - controller clock, async active-high reset
//             req_*                - host request (valid/ready handshake)
//             rsp_valid, rsp_rdata - one-cycle completion pulse + read byte
//             init_done            - PSRAM reset sequence has been sent
//             psram_ce_n           - chip select, active low
//             psram_clk_en         - gate for the PSRAM clock (~sclk)
//             sio_out/sio_oe/sio_in- quad data pins and per-pin enables
//  Revision : 1.0 - initial release
// ============================================================================
module psram_qspi_controller #(
    parameter int POWERUP_CYCLES  = 15000,
    parameter int WAIT_CYCLES     = 6,
    parameter int DESELECT_CYCLES = 2
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        init_done,
    output logic        psram_ce_n,
    output logic        psram_clk_en,
    output logic [3:0]  sio_out,
    output logic [3:0]  sio_oe,
    input  logic [3:0]  sio_in
);

    // One shared cycle counter; sized for the longest phase.
    localparam int c_max_pw  = (POWERUP_CYCLES > WAIT_CYCLES) ? POWERUP_CYCLES : WAIT_CYCLES;
    localparam int c_max_pwd = (c_max_pw > DESELECT_CYCLES) ? c_max_pw : DESELECT_CYCLES;
    localparam int c_max     = (c_max_pwd > 8) ? c_max_pwd : 8;
    localparam int c_cnt_w   = $clog2(c_max + 1);

    localparam logic [c_cnt_w-1:0] c_pwr_last   = c_cnt_w'(POWERUP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_wait_last  = c_cnt_w'(WAIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_desel_last = c_cnt_w'(DESELECT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cmd_last   = c_cnt_w'(7);
    localparam logic [c_cnt_w-1:0] c_addr_last  = c_cnt_w'(5);
    localparam logic [c_cnt_w-1:0] c_data_last  = c_cnt_w'(1);

    typedef enum logic [2:0] {
        S_POWERUP  = 3'd0,
        S_INIT_CMD = 3'd1,
        S_DESEL    = 3'd2,
        S_IDLE     = 3'd3,
        S_CMD      = 3'd4,
        S_ADDR     = 3'd5,
        S_WAIT     = 3'd6,
        S_DATA     = 3'd7
    } state_t;

    state_t               r_state, w_state_nx;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nx;
    logic                 r_sent_66, w_sent_66_nx;
    logic                 w_done_nx;
    logic                 w_accept;

    logic                 r_wr;
    logic [23:0]          r_addr;
    logic [7:0]           r_wdata;
    logic [3:0]           r_hi;
    logic                 r_rd_cap;
    logic                 r_rd_idx;

    logic                 w_ce_n;
    logic                 w_clk_en;
    logic [3:0]           w_oe;
    logic [3:0]           w_out;
    logic                 w_rsp;
    logic                 w_rd_cap;
    logic                 w_rd_idx;
    logic [7:0]           w_cmd;
    logic [23:0]          w_addr_sh;

    // ------------------------------------------------------------------------
    // State register. req_ready and init_done follow the next state so that
    // ready drops on the accepting edge itself.
    // ------------------------------------------------------------------------
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_state   <= S_POWERUP;
            r_cnt     <= '0;
            r_sent_66 <= 1'b0;
            init_done <= 1'b0;
            req_ready <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_sent_66 <= w_sent_66_nx;
            init_done <= w_done_nx;
            req_ready <= (w_state_nx == S_IDLE) && w_done_nx;
            if (w_accept) begin
                r_wr    <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state plus the pin values for the current state. The pin values are
    // registered below, so the pins show a state one cycle after it is entered.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt + 1'b1;
        w_sent_66_nx = r_sent_66;
        w_done_nx    = init_done;
        w_accept     = 1'b0;

        w_ce_n       = 1'b1;
        w_clk_en     = 1'b0;
        w_oe         = 4'b0000;
        w_out        = 4'b0000;
        w_rsp        = 1'b0;
        w_rd_cap     = 1'b0;
        w_rd_idx     = 1'b0;

        if (r_state == S_INIT_CMD) begin
            w_cmd = r_sent_66 ? 8'h99 : 8'h66;
        end else begin
            w_cmd = r_wr ? 8'h38 : 8'hEB;
        end
        // Nibble 0 of the address is bits [23:20]; shift it into the top.
        w_addr_sh = r_addr << {r_cnt[2:0], 2'b00};

        case (r_state)
            S_POWERUP: begin
                if (r_cnt == c_pwr_last) begin
                    w_state_nx = S_INIT_CMD;
                    w_cnt_nx   = '0;
                end
            end
            S_INIT_CMD, S_CMD: begin
                w_ce_n   = 1'b0;
                w_clk_en = 1'b1;
                w_oe     = 4'b0001;
                w_out[0] = w_cmd[3'd7 - r_cnt[2:0]];
                if (r_cnt == c_cmd_last) begin
                    w_state_nx = (r_state == S_CMD) ? S_ADDR : S_DESEL;
                    w_cnt_nx   = '0;
                end
            end
            S_DESEL: begin
                // Only transaction deselects follow a completed init.
                w_rsp = init_done && (r_cnt == '0);
                if (r_cnt == c_desel_last) begin
                    w_cnt_nx = '0;
                    if (!r_sent_66) begin
                        w_sent_66_nx = 1'b1;
                        w_state_nx   = S_INIT_CMD;
                    end else begin
                        w_done_nx  = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                w_cnt_nx = '0;
                if (req_valid && req_ready) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_CMD;
                end
            end
            S_ADDR: begin
                w_ce_n   = 1'b0;
                w_clk_en = 1'b1;
                w_oe     = 4'b1111;
                w_out    = w_addr_sh[23:20];
                if (r_cnt == c_addr_last) begin
                    w_cnt_nx   = '0;
                    w_state_nx = (r_wr || (WAIT_CYCLES == 0)) ? S_DATA : S_WAIT;
                end
            end
            S_WAIT: begin
                w_ce_n   = 1'b0;
                w_clk_en = 1'b1;
                if (r_cnt == c_wait_last) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                w_ce_n   = 1'b0;
                w_clk_en = 1'b1;
                w_rd_idx = r_cnt[0];
                if (r_wr) begin
                    w_oe  = 4'b1111;
                    w_out = r_cnt[0] ? r_wdata[3:0] : r_wdata[7:4];
                end else begin
                    w_rd_cap = 1'b1;
                end
                if (r_cnt == c_data_last) begin
                    w_cnt_nx   = '0;
                    w_state_nx = S_DESEL;
                end
            end
            default: begin
                w_state_nx = S_POWERUP;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered pins. Read nibbles are sampled on the edge that ends the data
    // cycle currently on the pins; the low nibble lands with rsp_valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            psram_ce_n   <= 1'b1;
            psram_clk_en <= 1'b0;
            sio_oe       <= 4'b0000;
            sio_out      <= 4'b0000;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 8'h00;
            r_hi         <= 4'h0;
            r_rd_cap     <= 1'b0;
            r_rd_idx     <= 1'b0;
        end else begin
            psram_ce_n   <= w_ce_n;
            psram_clk_en <= w_clk_en;
            sio_oe       <= w_oe;
            sio_out      <= w_out;
            rsp_valid    <= w_rsp;
            r_rd_cap     <= w_rd_cap;
            r_rd_idx     <= w_rd_idx;
            if (r_rd_cap && !r_rd_idx) begin
                r_hi <= sio_in;
            end
            if (w_rsp) begin
                rsp_rdata <= r_wr ? 8'h00 : {r_hi, sio_in};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psram_qspi_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psram_qspi_controller
//  Purpose  : Bench for psram_qspi_controller. A PSRAM pin model decodes each
//             chip-select frame into command/address/data and answers quad
//             reads; issued requests queue expected frames and responses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_psram_qspi_controller;

    localparam int TB_POWERUP = 4;
    localparam int TB_WAIT    = 6;
    localparam int TB_DESEL   = 2;

    logic        sclk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [23:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        init_done;
    logic        psram_ce_n;
    logic        psram_clk_en;
    logic [3:0]  sio_out;
    logic [3:0]  sio_oe;
    logic [3:0]  sio_in_drv = 4'h0;

    psram_qspi_controller #(
        .POWERUP_CYCLES (TB_POWERUP),
        .WAIT_CYCLES    (TB_WAIT),
        .DESELECT_CYCLES(TB_DESEL)
    ) dut (
        .sclk        (sclk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .init_done   (init_done),
        .psram_ce_n  (psram_ce_n),
        .psram_clk_en(psram_clk_en),
        .sio_out     (sio_out),
        .sio_oe      (sio_oe),
        .sio_in      (sio_in_drv)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [7:0] rdata; int cyc; } rsp_t;
    typedef struct { logic [7:0] cmd; logic [23:0] addr; logic [7:0] data; int len; } frm_t;

    rsp_t sb_q[$];
    frm_t fq[$];
    logic [7:0] ref_mem   [logic [23:0]];
    logic [7:0] psram_mem [logic [23:0]];

    function automatic logic [7:0] dflt(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] psram_rd(input logic [23:0] a);
        if (psram_mem.exists(a)) return psram_mem[a];
        return dflt(a);
    endfunction

    // ---------------- response monitor ----------------
    always @(posedge sclk) begin
        rsp_t e;
        #1;
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_edge", cyc, e.cyc);
            end
        end
    end

    // ---------------- PSRAM pin model (samples on falling sclk) ----------------
    int         m_k = 0;
    int         m_gap = 99;
    int         frames_seen = 0;
    bit         m_in = 0, m_bad = 0, m_rdy_bad = 0, m_clk_bad = 0;
    logic [7:0] m_cmd, m_data;
    logic [23:0] m_addr;

    task automatic finish_frame();
        frm_t ef;
        frames_seen++;
        if (fq.size() == 0) begin
            chk("unexpected_frame", 1, 0);
        end else begin
            ef = fq.pop_front();
            chk("frame_cmd", m_cmd, ef.cmd);
            chk("frame_len", m_k, ef.len);
            if (ef.len != 8) chk("frame_addr", m_addr, ef.addr);
            if (ef.cmd == 8'h38) chk("frame_wdata", m_data, ef.data);
            chk("frame_pins", m_bad, 0);
            chk("frame_ready_low", m_rdy_bad, 0);
        end
        if (m_cmd == 8'h38 && m_k == 16) psram_mem[m_addr] = m_data;
    endtask

    always @(negedge sclk) begin
        sio_in_drv = 4'($urandom);
        if (reset) begin
            m_in = 0; m_k = 0; m_gap = 99; m_clk_bad = 0;
        end else if (!psram_ce_n) begin
            if (!m_in) begin
                chk("desel_gap", {m_gap >= TB_DESEL, m_clk_bad}, 2'b10);
                m_in = 1; m_k = 0; m_bad = 0; m_rdy_bad = 0; m_clk_bad = 0;
                m_cmd = 0; m_addr = 0; m_data = 0;
            end
            if (!psram_clk_en) m_bad = 1;
            if (req_ready) m_rdy_bad = 1;
            if (m_k < 8) begin
                if (sio_oe != 4'b0001) m_bad = 1;
                m_cmd = {m_cmd[6:0], sio_out[0]};
            end else if (m_k < 14) begin
                if (sio_oe != 4'b1111) m_bad = 1;
                m_addr = {m_addr[19:0], sio_out};
            end else if (m_cmd == 8'h38) begin
                if (sio_oe != 4'b1111) m_bad = 1;
                m_data = {m_data[3:0], sio_out};
            end else begin
                if (sio_oe != 4'b0000) m_bad = 1;
                // Data is presented after the falling edge of each data cycle.
                if (m_k == 14 + TB_WAIT) begin
                    m_data = psram_rd(m_addr);
                    sio_in_drv = m_data[7:4];
                end
                if (m_k == 15 + TB_WAIT) sio_in_drv = m_data[3:0];
            end
            m_k++;
        end else begin
            if (psram_clk_en) m_clk_bad = 1;
            if (m_in) begin
                m_in = 0;
                finish_frame();
                m_gap = 1;
            end else begin
                m_gap++;
            end
        end
    end

    // ---------------- stimulus ----------------
    int last_accept = 0;
    int init_edge = 0;

    task automatic do_reset(input bit early);
        int r;
        bit seen;
        frm_t f;
        @(negedge sclk);
        reset = 1'b1;
        #1;
        chk("rst_ce_n", psram_ce_n, 1);
        chk("rst_clk_en", psram_clk_en, 0);
        chk("rst_sio_oe", sio_oe, 0);
        chk("rst_sio_out", sio_out, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_init_done", init_done, 0);
        sb_q.delete();
        fq.delete();
        f.addr = 0; f.data = 0; f.len = 8;
        f.cmd = 8'h66; fq.push_back(f);
        f.cmd = 8'h99; fq.push_back(f);
        frames_seen = 0;
        req_valid = early;
        req_write = 1'b1;
        req_addr  = 24'hABCDEF;
        req_wdata = 8'h77;
        repeat (3) @(negedge sclk);
        reset = 1'b0;
        r = cyc;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge sclk); #1;
            if (!psram_ce_n) seen = 1;
        end
        chk("ce_n_fall_edge", cyc - r, 5);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge sclk); #1;
            if (init_done) seen = 1;
        end
        init_edge = cyc;
        chk("init_done_seen", seen, 1);
        chk("init_frames", frames_seen, 2);
    endtask

    task automatic issue(input bit wr, input logic [23:0] a, input logic [7:0] d, input bit hold);
        frm_t f;
        rsp_t e;
        bit ok;
        f.cmd = wr ? 8'h38 : 8'hEB;
        f.addr = a;
        f.data = wr ? d : 8'h00;
        f.len = wr ? 16 : 16 + TB_WAIT;
        fq.push_back(f);
        @(negedge sclk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                ok = 1;
                break;
            end
            @(negedge sclk);
        end
        chk("accept_timeout", ok, 1);
        if (!ok) begin
            req_valid = 1'b0;
            void'(fq.pop_back());
            return;
        end
        @(posedge sclk); #1;
        last_accept = cyc;
        e.rdata = wr ? 8'h00 : ref_rd(a);
        e.cyc   = cyc + (wr ? 17 : 23 + (TB_WAIT - 6));
        if (wr) ref_mem[a] = d;
        sb_q.push_back(e);
        // Inputs after the accepting edge must not matter.
        req_valid = hold;
        req_write = 1'($urandom);
        req_addr  = 24'($urandom);
        req_wdata = 8'($urandom);
    endtask

    logic [23:0] pool [6];

    initial begin
        bit wr, hold;
        for (int i = 0; i < 6; i++) pool[i] = 24'($urandom);

        // Power-up and init sequence.
        do_reset(0);

        // Quad write, then quad read with a known byte.
        issue(1, 24'h123456, 8'h5A, 0);
        psram_mem[24'h000010] = 8'hC3;
        ref_mem[24'h000010]   = 8'hC3;
        issue(0, 24'h000010, 8'h00, 0);
        issue(0, 24'h123456, 8'h00, 0);

        // Back-to-back reads with req_valid held high.
        issue(0, 24'h800001, 8'h00, 1);
        issue(0, 24'h000010, 8'h00, 0);

        // Reset in the middle of the WAIT phase of a read.
        issue(0, 24'h654321, 8'h00, 0);
        while (cyc < last_accept + 17) @(posedge sclk);
        #1;
        chk("in_wait_pins", {psram_ce_n, psram_clk_en, sio_oe}, 6'b010000);
        do_reset(0);
        ref_mem.delete();
        psram_mem.delete();

        // Request already pending during power-up.
        do_reset(1);
        issue(1, 24'hABCDEF, 8'h77, 0);
        chk("early_accept_edge", last_accept, init_edge + 1);

        // Randomized traffic over a small address pool.
        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom);
            hold = (n != 39) && ($urandom_range(0, 2) == 0);
            issue(wr, pool[$urandom_range(0, 5)], 8'($urandom), hold);
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge sclk);
        end
        req_valid = 1'b0;

        for (int i = 0; i < 600 && (sb_q.size() != 0 || fq.size() != 0); i++) @(posedge sclk);
        repeat (5) @(posedge sclk);
        chk("drain", sb_q.size() + fq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
